// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IF/LS memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Transaction sequencer states; exported on the dbg_state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant logic for the arbiter: LS priority with an IF starvation guard.
// The grant outputs are combinational and are only meaningful while the
// parent FSM is idle. The starvation count advances only on accepted grants.
module mem_arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_valid,
    input  logic       ls_valid,
    input  logic       accept,
    output logic       grant_if,
    output logic       grant_ls,
    output logic [3:0] starve_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic if_forced;

    // IF wins once it has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        if_forced = if_valid && (starve_cnt == CNT_MAX);
        grant_ls  = ls_valid && !if_forced;
        grant_if  = if_valid && !grant_ls;
    end

    // Count LS wins that happened while IF was waiting; any IF win clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (grant_if) begin
                starve_cnt <= '0;
            end else if (grant_ls && if_valid && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// Handshake: a request transfers in the cycle where req_valid and req_ready
// are both 1. ready is only ever raised in IDLE and only for the granted
// requester, so at most one request is accepted per transaction slot.
// Each transaction: IDLE (accept) -> ISSUE (mem_valid pulse) -> WAIT
// (MEM_LAT cycles, read data captured in the last) -> RESP (resp_valid pulse).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction fetch port
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    // load/store port
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    // memory port
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    // observability
    output arb_state_t          dbg_state,
    output logic [3:0]          dbg_starve_cnt
);

    localparam int         MASK_W  = DATA_W / 8;
    localparam logic [3:0] LAT_VAL = 4'(MEM_LAT);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [3:0]          lat_cnt;
    owner_t              owner;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_wen;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [MASK_W-1:0]   cmd_wmask;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   ls_rdata_q;

    logic idle;
    logic grant_if;
    logic grant_ls;
    logic accept;
    logic last_wait;

    assign idle      = (state == ST_IDLE);
    assign accept    = idle && (grant_if || grant_ls);
    assign last_wait = (state == ST_WAIT) && (lat_cnt == 4'd1);

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_req_valid),
        .ls_valid   (ls_req_valid),
        .accept     (accept),
        .grant_if   (grant_if),
        .grant_ls   (grant_ls),
        .starve_cnt (dbg_starve_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one fixed walk through the four states per transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (lat_cnt == 4'd1) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latency counter: loaded while issuing, counts the WAIT cycles down to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            lat_cnt <= LAT_VAL;
        end else if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
        end
    end

    // Command latch: captured at the handshake and held until the next one,
    // so the mem_* fields stay stable from ISSUE until the next ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_IF;
            cmd_addr  <= '0;
            cmd_wen   <= 1'b0;
            cmd_wdata <= '0;
            cmd_wmask <= '0;
        end else if (accept) begin
            if (grant_ls) begin
                owner     <= OWN_LS;
                cmd_addr  <= ls_addr;
                cmd_wen   <= ls_wen;
                cmd_wdata <= ls_wdata;
                cmd_wmask <= ls_wen ? ls_wmask : '0;
            end else begin
                owner     <= OWN_IF;
                cmd_addr  <= if_addr;
                cmd_wen   <= 1'b0;
                cmd_wdata <= '0;
                cmd_wmask <= '0;
            end
        end
    end

    // Read data capture in the final WAIT cycle; writes leave both registers alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else if (last_wait && !cmd_wen) begin
            if (owner == OWN_LS) begin
                ls_rdata_q <= mem_rdata;
            end else begin
                if_rdata_q <= mem_rdata;
            end
        end
    end

    // Output decode. ready is gated by rst_n so every output reads 0 during reset.
    always_comb begin
        if_req_ready  = rst_n && idle && grant_if;
        ls_req_ready  = rst_n && idle && grant_ls;
        mem_valid     = (state == ST_ISSUE);
        mem_addr      = cmd_addr;
        mem_wen       = cmd_wen;
        mem_wdata     = cmd_wdata;
        mem_wmask     = cmd_wmask;
        if_resp_valid = (state == ST_RESP) && (owner == OWN_IF);
        ls_resp_valid = (state == ST_RESP) && (owner == OWN_LS);
        if_rdata      = if_rdata_q;
        ls_rdata      = ls_rdata_q;
        dbg_state     = state;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for starvation, reset mid-flight, MEM_LAT=3 timing
// and a request pulse that vanishes before IDLE.
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared request inputs
    logic        if_req_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_req_valid = 1'b0;
    logic [31:0] ls_addr = '0;
    logic        ls_wen = 1'b0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_wmask = '0;

    // MEM_LAT=1 instance outputs
    logic        if_req_ready, if_resp_valid, ls_req_ready, ls_resp_valid;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, mem_wen;
    logic [3:0]  mem_wmask, dbg_starve_cnt;
    logic [1:0]  dbg_state;

    // MEM_LAT=3 instance outputs
    logic        d3_if_req_ready, d3_if_resp_valid, d3_ls_req_ready, d3_ls_resp_valid;
    logic [31:0] d3_if_rdata, d3_ls_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
    logic        d3_mem_valid, d3_mem_wen;
    logic [3:0]  d3_mem_wmask, d3_dbg_starve_cnt;
    logic [1:0]  d3_dbg_state;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(d3_if_req_ready), .if_addr(if_addr),
        .if_resp_valid(d3_if_resp_valid), .if_rdata(d3_if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(d3_ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(d3_ls_resp_valid), .ls_rdata(d3_ls_rdata),
        .mem_valid(d3_mem_valid), .mem_addr(d3_mem_addr), .mem_wen(d3_mem_wen),
        .mem_wdata(d3_mem_wdata), .mem_wmask(d3_mem_wmask), .mem_rdata(d3_mem_rdata),
        .dbg_state(d3_dbg_state), .dbg_starve_cnt(d3_dbg_starve_cnt)
    );

    // ---------------- memory models ----------------
    // Read data is only correct in the exact cycle MEM_LAT after mem_valid.
    localparam logic [31:0] JUNK = 32'hBAD0BAD0;
    logic [31:0] rd_val = '0;
    logic [31:0] rd_val3 = '0;
    logic [2:0]  pipe1 = '0;
    logic [2:0]  pipe3 = '0;
    always @(posedge clk) begin
        pipe1 <= {pipe1[1:0], mem_valid};
        pipe3 <= {pipe3[1:0], d3_mem_valid};
    end
    assign mem_rdata    = pipe1[0] ? rd_val  : JUNK;
    assign d3_mem_rdata = pipe3[2] ? rd_val3 : JUNK;

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_ls;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rd;
        logic [3:0]  exp_mask;
        logic [31:0] exp_if;
        logic [31:0] exp_ls;
    } vec_t;

    vec_t vecs[5];

    // One transaction on the MEM_LAT=1 instance; starts and ends idle at posedge+1.
    task automatic do_txn(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        rd_val = v.rd;
        if (v.is_ls) begin
            ls_req_valid = 1'b1; ls_addr = v.addr; ls_wen = v.wen;
            ls_wdata = v.wdata; ls_wmask = v.wmask;
        end else begin
            if_req_valid = 1'b1; if_addr = v.addr;
        end
        @(negedge clk); // T
        chk({p, "_if_ready"}, 64'(if_req_ready), 64'(!v.is_ls));
        chk({p, "_ls_ready"}, 64'(ls_req_ready), 64'(v.is_ls));
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(negedge clk); // T+1
        chk({p, "_mem_valid"}, 64'(mem_valid), 64'd1);
        chk({p, "_mem_addr"},  64'(mem_addr), 64'(v.addr));
        chk({p, "_mem_wen"},   64'(mem_wen), 64'(v.wen));
        chk({p, "_mem_wmask"}, 64'(mem_wmask), 64'(v.exp_mask));
        if (v.wen) chk({p, "_mem_wdata"}, 64'(mem_wdata), 64'(v.wdata));
        chk({p, "_ready_busy"}, 64'(if_req_ready | ls_req_ready), 64'd0);
        tick();
        @(negedge clk); // T+2
        chk({p, "_mem_valid_t2"}, 64'(mem_valid), 64'd0);
        chk({p, "_resp_early"}, 64'({if_resp_valid, ls_resp_valid}), 64'd0);
        tick();
        @(negedge clk); // T+3
        chk({p, "_if_resp"}, 64'(if_resp_valid), 64'(!v.is_ls));
        chk({p, "_ls_resp"}, 64'(ls_resp_valid), 64'(v.is_ls));
        chk({p, "_if_rdata"}, 64'(if_rdata), 64'(v.exp_if));
        chk({p, "_ls_rdata"}, 64'(ls_rdata), 64'(v.exp_ls));
        tick();
        @(negedge clk); // T+4
        chk({p, "_resp_once"}, 64'({if_resp_valid, ls_resp_valid}), 64'd0);
        chk({p, "_idle"}, 64'(dbg_state), 64'd0);
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        int  grants;
        int  cnt;
        bit  got[10];
        bit  exp_seq[10];

        vecs[0] = '{0, 32'h10, 0, 32'h0,       4'h0, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 32'h20, 1, 32'h12345678, 4'hF, JUNK,       4'hF, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1, 32'h24, 0, 32'h11111111, 4'h3, 32'hCAFEF00D, 4'h0, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1, 32'h28, 1, 32'hAAAA5555, 4'h5, JUNK,       4'h5, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{0, 32'h14, 0, 32'h0,       4'h0, 32'h01020304, 4'h0, 32'h01020304, 32'hCAFEF00D};
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // reset values
        rst_n = 1'b0;
        if_req_valid = 1'b1; // ready must still stay low under reset
        #12;
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_cmd", {mem_addr, 28'(mem_wdata), mem_wen, mem_wmask[2:0]}, 64'd0);
        chk("rst_resp", 64'({if_resp_valid, ls_resp_valid}), 64'd0);
        chk("rst_rdata", {if_rdata, ls_rdata}, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_starve", 64'(dbg_starve_cnt), 64'd0);
        do_reset();

        // table-driven single transactions
        for (int i = 0; i < 5; i++) do_txn(vecs[i], i);

        // starvation: both requesters hold valid continuously
        do_reset();
        if_addr = 32'h100; ls_addr = 32'h200; ls_wen = 1'b0;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        grants = 0;
        for (int c = 0; c < 80 && grants < 10; c++) begin
            @(negedge clk);
            chk("starve_exclusive", 64'(if_req_ready & ls_req_ready), 64'd0);
            if (ls_req_ready) begin got[grants] = 1'b1; grants++; end
            else if (if_req_ready) begin got[grants] = 1'b0; grants++; end
        end
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        chk("starve_grant_count", 64'(grants), 64'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("starve_grant%0d", i), 64'(got[i]), 64'(exp_seq[i]));

        // reset asserted during WAIT of an IF read
        do_reset();
        rd_val = 32'h77777777;
        if_req_valid = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        chk("mr_if_ready", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid = 1'b0;
        tick(); // now in WAIT
        chk("mr_in_wait", 64'(dbg_state), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mr_state", 64'(dbg_state), 64'd0);
        chk("mr_outputs", 64'({mem_valid, mem_wen, if_resp_valid, ls_resp_valid,
                                if_req_ready, ls_req_ready}), 64'd0);
        chk("mr_mem_addr", 64'(mem_addr), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if_resp_valid) cnt++;
        end
        chk("mr_no_resp", 64'(cnt), 64'd0);
        chk("mr_if_rdata", 64'(if_rdata), 64'd0);
        tick();
        do_txn(vecs[0], 10);

        // MEM_LAT=3: LS read, valid held high throughout
        do_reset();
        rd_val3 = 32'h0BADF00D;
        ls_req_valid = 1'b1; ls_addr = 32'h40; ls_wen = 1'b0;
        @(negedge clk); // T
        chk("l3_ready_t", 64'(d3_ls_req_ready), 64'd1);
        tick();
        @(negedge clk); // T+1
        chk("l3_mem_valid", 64'(d3_mem_valid), 64'd1);
        chk("l3_mem_addr", 64'(d3_mem_addr), 64'h40);
        chk("l3_ready_t1", 64'(d3_ls_req_ready), 64'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("l3_quiet_t%0d", k),
                64'({d3_ls_req_ready, d3_ls_resp_valid, d3_mem_valid}), 64'd0);
        end
        tick();
        @(negedge clk); // T+5
        chk("l3_ready_t5", 64'(d3_ls_req_ready), 64'd0);
        chk("l3_resp", 64'(d3_ls_resp_valid), 64'd1);
        chk("l3_rdata", 64'(d3_ls_rdata), 64'h0BADF00D);
        chk("l3_if_resp", 64'(d3_if_resp_valid), 64'd0);
        tick();
        ls_req_valid = 1'b0;

        // IF valid pulsed during WAIT only, dropped before IDLE
        do_reset();
        rd_val = 32'h55AA55AA;
        ls_req_valid = 1'b1; ls_addr = 32'h50; ls_wen = 1'b0;
        @(negedge clk);
        chk("pu_ls_ready", 64'(ls_req_ready), 64'd1);
        tick();
        ls_req_valid = 1'b0;
        tick(); // WAIT
        if_req_valid = 1'b1; if_addr = 32'h60;
        @(negedge clk);
        chk("pu_if_ready_wait", 64'(if_req_ready), 64'd0);
        tick(); // RESP
        if_req_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_valid || if_resp_valid || if_req_ready) cnt++;
        end
        chk("pu_no_activity", 64'(cnt), 64'd0);
        chk("pu_starve", 64'(dbg_starve_cnt), 64'd0);
        chk("pu_ls_rdata", 64'(ls_rdata), 64'h55AA55AA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port instruction/data memory between the instruction-fetch unit (IF) and the load/store unit (LS).
- Accepts one request at a time over valid/ready handshakes and issues it to the memory as a one-cycle command.
- Waits a fixed memory latency, then returns read data (or a write acknowledge) to the granted requester.
- LS has priority; a starvation counter guarantees IF forward progress.

Parameters:
ADDR_W, 32, address width of requests and memory port
DATA_W, 32, data word width (matches instruction width)
MEM_LAT, 1, cycles from mem_valid to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, consecutive lost IF arbitrations before IF is forced to win; legal range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  IF request present
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_W  IF fetch address
if_resp_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched word
ls_req_valid  in  1  LS request present
ls_req_ready  out  1  LS request accepted this cycle
ls_addr  in  ADDR_W  LS address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  DATA_W  write data
ls_wmask  in  DATA_W/8  byte enables for writes
ls_resp_valid  out  1  one-cycle pulse, read data valid or write done
ls_rdata  out  DATA_W  load data
mem_valid  out  1  one-cycle command strobe
mem_addr  out  ADDR_W  command address
mem_wen  out  1  command is write
mem_wdata  out  DATA_W  write data
mem_wmask  out  DATA_W/8  byte enables, 0 for reads
mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after mem_valid

Behaviour:
- Reset (async assert, sync-deasserted externally): state=IDLE, all outputs 0, rdata registers 0, starve_cnt 0, owner=IF.
- Reset mid-transaction drops the in-flight request; no response is produced.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: grant is combinational. Only the granted requester sees ready=1, and ready is 1 only in IDLE.
  - Grant = LS if ls_req_valid and not (if_req_valid and starve_cnt==STARVE_MAX); else IF if if_req_valid.
  - On handshake (cycle T): latch addr/wen/wdata/wmask/owner, go to ISSUE. IF requests latch wen=0, wmask=0.
- ISSUE (T+1): mem_valid=1 with the latched command; load the latency counter with MEM_LAT; go to WAIT.
- WAIT: lasts MEM_LAT cycles. In the last one (T+1+MEM_LAT), the owner's rdata register captures mem_rdata if it is a read.
- RESP (T+2+MEM_LAT): owner's resp_valid=1 for exactly one cycle; go to IDLE.
  - Request-to-response latency is MEM_LAT+2 cycles; one transaction per MEM_LAT+3 cycles.
- Write: ls_resp_valid still pulses; ls_rdata keeps its previous value.
- if_rdata/ls_rdata hold their value until the next read for that requester.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each LS grant while if_req_valid=1.
  - Clears on any IF grant.
  - Unchanged otherwise.
- mem_* outputs other than mem_valid hold the latched command from ISSUE until the next ISSUE.
- Requesters may drop valid before the handshake without effect; a valid asserted outside IDLE waits.
- Addresses pass unmodified; alignment and mask generation are the LS unit's responsibility.
- Never two responses in one cycle; never a response without a prior handshake.

Decomposition:
- Shared `defines.v`: FSM state encodings (2-bit), owner encoding (IF=0, LS=1), ADDR_W/DATA_W defaults.
- One natural sub-module, mem_arb_grant: holds starve_cnt and produces the grant.
  - Inputs: both valids, the accept strobe.
  - Outputs: grant_if, grant_ls.
- The FSM, latency counter and datapath registers stay in mem_arbiter.

Test Plan:
- Single IF read, MEM_LAT=1, if_addr=0x10, mem returns 0xDEADBEEF -> mem_valid at T+1 with addr 0x10; if_resp_valid at T+3 with if_rdata=0xDEADBEEF; ls_resp_valid stays 0.
- LS write addr=0x20, wdata=0x12345678, wmask=0xF -> mem_valid/mem_wen=1, mem_wmask=0xF at T+1; ls_resp_valid at T+3; ls_rdata unchanged.
- Both valid continuously, STARVE_MAX=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; if_req_ready never 1 while LS wins.
- MEM_LAT=3, LS read -> mem_valid at T+1; rdata sampled at T+4; ls_resp_valid at T+5; ready=0 during T+1..T+5.
- rst_n asserted in WAIT of an IF read -> all outputs 0 immediately; no if_resp_valid after release; next request handled normally.
- if_req_valid pulsed during WAIT then dropped before IDLE -> no grant, no mem_valid, starve_cnt unchanged.
